// File: rtl/fmultiplier.sv
// fmultiplier: two-stage IEEE-754 binary32 multiplier with round-to-nearest-even,
// flush-to-zero on subnormal inputs and an exception flag for NaN/Inf results.
module fmultiplier (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic [31:0] result,
  output logic        exception
);

  localparam int unsigned ExpW  = 8;
  localparam int unsigned FracW = 23;
  localparam int unsigned SigW  = FracW + 1;
  localparam int unsigned ProdW = 2 * SigW;
  localparam int unsigned EsumW = 10;

  typedef enum logic [1:0] {
    CLS_NORM = 2'd0,
    CLS_ZERO = 2'd1,
    CLS_INF  = 2'd2,
    CLS_NAN  = 2'd3
  } cls_e;

  // stage 1 registers
  logic                    sign_q, sign_d;
  logic signed [EsumW-1:0] exp_q, exp_d;
  logic [ProdW-1:0]        prod_q, prod_d;
  cls_e                    cls_q, cls_d;

  // stage 2 next-state
  logic [31:0] result_d;
  logic        exception_d;

  logic [ExpW-1:0]  exp_a, exp_b;
  logic [FracW-1:0] frac_a, frac_b;
  logic             a_nan, a_inf, a_zero, b_nan, b_inf, b_zero;

  // Stage 1: sign, biased exponent sum, significand product and operand class
  always_comb begin
    exp_a  = A[30:23];
    exp_b  = B[30:23];
    frac_a = A[22:0];
    frac_b = B[22:0];
    a_nan  = (&exp_a) & (|frac_a);
    a_inf  = (&exp_a) & ~(|frac_a);
    a_zero = ~(|exp_a);
    b_nan  = (&exp_b) & (|frac_b);
    b_inf  = (&exp_b) & ~(|frac_b);
    b_zero = ~(|exp_b);

    sign_d = A[31] ^ B[31];
    exp_d  = $signed({2'b00, exp_a}) + $signed({2'b00, exp_b}) - 10'sd127;
    prod_d = ProdW'({1'b1, frac_a}) * ProdW'({1'b1, frac_b});

    if (a_nan | b_nan | (a_zero & b_inf) | (a_inf & b_zero)) begin
      cls_d = CLS_NAN;
    end else if (a_inf | b_inf) begin
      cls_d = CLS_INF;
    end else if (a_zero | b_zero) begin
      cls_d = CLS_ZERO;
    end else begin
      cls_d = CLS_NORM;
    end
  end

  logic                    norm;
  logic [FracW-1:0]        mant;
  logic                    g_bit, r_bit, s_bit, rnd_up;
  logic [SigW-1:0]         mant_r;
  logic signed [EsumW-1:0] exp_n, exp_f;
  logic [FracW-1:0]        frac_f;

  // Stage 2: normalize, round to nearest even, renormalize, then range/special select
  always_comb begin
    norm   = prod_q[47];
    mant   = norm ? prod_q[46:24] : prod_q[45:23];
    g_bit  = norm ? prod_q[23] : prod_q[22];
    r_bit  = norm ? prod_q[22] : prod_q[21];
    s_bit  = norm ? (|prod_q[21:0]) : (|prod_q[20:0]);
    exp_n  = exp_q + (norm ? 10'sd1 : 10'sd0);
    rnd_up = g_bit & (r_bit | s_bit | mant[0]);
    mant_r = {1'b0, mant} + SigW'(rnd_up);
    exp_f  = exp_n + (mant_r[23] ? 10'sd1 : 10'sd0);
    frac_f = mant_r[23] ? '0 : mant_r[22:0];

    result_d    = 32'h0000_0000;
    exception_d = 1'b0;
    case (cls_q)
      CLS_NAN: begin
        result_d    = 32'h7FC0_0000;
        exception_d = 1'b1;
      end
      CLS_INF: begin
        result_d    = {sign_q, 8'hFF, 23'd0};
        exception_d = 1'b1;
      end
      CLS_ZERO: begin
        result_d = {sign_q, 31'd0};
      end
      default: begin
        if (exp_f <= 10'sd0) begin
          result_d = {sign_q, 31'd0};
        end else if (exp_f >= 10'sd255) begin
          result_d    = {sign_q, 8'hFF, 23'd0};
          exception_d = 1'b1;
        end else begin
          result_d = {sign_q, exp_f[7:0], frac_f};
        end
      end
    endcase
  end

  // Pipeline registers, cleared asynchronously by reset_n
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sign_q    <= 1'b0;
      exp_q     <= '0;
      prod_q    <= '0;
      cls_q     <= CLS_NORM;
      result    <= 32'h0000_0000;
      exception <= 1'b0;
    end else begin
      sign_q    <= sign_d;
      exp_q     <= exp_d;
      prod_q    <= prod_d;
      cls_q     <= cls_d;
      result    <= result_d;
      exception <= exception_d;
    end
  end

endmodule

// File: tb/tb_fmultiplier.sv
// tb_fmultiplier: directed and randomized checks of fmultiplier against an
// arithmetic binary32 reference model, including async reset behaviour.
module tb_fmultiplier;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] A, B;
  logic [31:0] result;
  logic        exception;

  int checks = 0;
  int errors = 0;

  string       pipe_tag [2];
  logic [32:0] pipe_exp [2];

  always #5 clk = ~clk;

  fmultiplier dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .A         (A),
    .B         (B),
    .result    (result),
    .exception (exception)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  // Reference: exact significand product, rounded by remainder vs. half-ulp
  function automatic logic [32:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
    int          ea, eb, e, sh;
    logic        s, a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    logic [47:0] p, q, rem, half;
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    s  = a[31] ^ b[31];
    a_nan  = (ea == 255) && (a[22:0] != 0);
    b_nan  = (eb == 255) && (b[22:0] != 0);
    a_inf  = (ea == 255) && (a[22:0] == 0);
    b_inf  = (eb == 255) && (b[22:0] == 0);
    a_zero = (ea == 0);
    b_zero = (eb == 0);
    if (a_nan || b_nan || (a_zero && b_inf) || (a_inf && b_zero)) return {1'b1, 32'h7FC00000};
    if (a_inf || b_inf) return {1'b1, s, 8'hFF, 23'd0};
    if (a_zero || b_zero) return {1'b0, s, 31'd0};
    p    = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
    sh   = p[47] ? 24 : 23;
    e    = ea + eb - 127 + (p[47] ? 1 : 0);
    q    = p >> sh;
    rem  = p - (q << sh);
    half = 48'(1) << (sh - 1);
    if ((rem > half) || ((rem == half) && q[0])) q = q + 48'(1);
    if (q == (48'(1) << 24)) begin
      q = q >> 1;
      e = e + 1;
    end
    if (e <= 0) return {1'b0, s, 31'd0};
    if (e >= 255) return {1'b1, s, 8'hFF, 23'd0};
    return {1'b0, s, 8'(e), q[22:0]};
  endfunction

  function automatic logic [31:0] rand_op();
    int          k;
    logic [7:0]  e;
    logic [22:0] f;
    logic        s;
    k = int'($urandom_range(0, 15));
    f = 23'($urandom);
    s = 1'($urandom);
    if (k == 0) begin
      e = 8'h00;
    end else if (k == 1) begin
      e = 8'hFF;
      if ($urandom_range(0, 1) == 0) f = '0;
    end else if (k < 8) begin
      e = 8'($urandom_range(1, 254));
    end else begin
      e = 8'($urandom_range(97, 157));
    end
    if ($urandom_range(0, 3) == 0) f[11:0] = '0;
    return {s, e, f};
  endfunction

  task automatic clear_pipe();
    for (int i = 0; i < 2; i++) begin
      pipe_tag[i] = "idle";
      pipe_exp[i] = '0;
    end
  endtask

  // One cycle: check the op issued two cycles ago, then issue a new op
  task automatic step(input string tag, input logic [31:0] a, input logic [31:0] b,
                      input logic [32:0] e);
    @(negedge clk);
    check({pipe_tag[1], ".res"}, result, pipe_exp[1][31:0]);
    check({pipe_tag[1], ".exc"}, 32'(exception), 32'(pipe_exp[1][32]));
    pipe_tag[1] = pipe_tag[0];
    pipe_exp[1] = pipe_exp[0];
    A = a;
    B = b;
    pipe_tag[0] = tag;
    pipe_exp[0] = e;
  endtask

  task automatic rand_step(input string tag);
    logic [31:0] a, b;
    a = rand_op();
    b = rand_op();
    step(tag, a, b, ref_mul(a, b));
  endtask

  initial begin
    reset_n = 1'b1;
    A = 32'h3F80_0000;
    B = 32'h4000_0000;
    clear_pipe();
    #2 reset_n = 1'b0;
    #1;
    check("rst_async.res", result, 32'h0);
    check("rst_async.exc", 32'(exception), 32'h0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      A = $urandom;
      B = $urandom;
      check("rst_hold.res", result, 32'h0);
      check("rst_hold.exc", 32'(exception), 32'h0);
    end
    A = '0;
    B = '0;
    @(negedge clk);
    reset_n = 1'b1;

    step("half",    32'h3F000000, 32'hC00B4B4B, {1'b0, 32'hBF8B4B4B});
    step("b2b_3",   32'h3FC00000, 32'h40000000, {1'b0, 32'h40400000});
    step("b2b_rnd", 32'h3F800001, 32'h3F800001, {1'b0, 32'h3F800002});
    step("ovf_pos", 32'h7F000000, 32'h40000000, {1'b1, 32'h7F800000});
    step("ovf_neg", 32'hFF000000, 32'h40000000, {1'b1, 32'hFF800000});
    step("zero_inf",32'h00000000, 32'h7F800000, {1'b1, 32'h7FC00000});
    step("nan_in",  32'h7FC00001, 32'h3F800000, {1'b1, 32'h7FC00000});
    step("unf",     32'h00800000, 32'h00800000, {1'b0, 32'h00000000});
    step("neg_zero",32'h80000000, 32'h3F800000, {1'b0, 32'h80000000});
    step("inf_inf", 32'hFF800000, 32'h7F800000, {1'b1, 32'hFF800000});
    step("one_one", 32'h3F800000, 32'h3F800000, {1'b0, 32'h3F800000});

    for (int i = 0; i < 400; i++) rand_step("rand");

    // Reset in flight: stale operands must not reappear
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("rst_mid.res", result, 32'h0);
    check("rst_mid.exc", 32'(exception), 32'h0);
    clear_pipe();
    A = '0;
    B = '0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_mid_hold.res", result, 32'h0);
      check("rst_mid_hold.exc", 32'(exception), 32'h0);
    end
    reset_n = 1'b1;

    for (int i = 0; i < 200; i++) rand_step("rand2");
    step("flush", 32'h0, 32'h0, {1'b0, 32'h0});
    step("flush", 32'h0, 32'h0, {1'b0, 32'h0});
    step("flush", 32'h0, 32'h0, {1'b0, 32'h0});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fmultiplier.md
FMULTIPLIER -- requirements
Module: fmultiplier

Interface
REQ-001 SHALL have no parameters; the format is fixed to IEEE-754 binary32.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port A, input, 32 bits: operand A, binary32 (sign[31], exp[30:23], frac[22:0]).
REQ-005 SHALL have port B, input, 32 bits: operand B, binary32.
REQ-006 SHALL have port result, output, 32 bits: registered binary32 product A*B.
REQ-007 SHALL have port exception, output, 1 bit: registered flag, high when result is NaN or ±Inf.

Function
REQ-008 SHALL be a 2-stage pipeline with latency 2: operands sampled at edge N appear on result/exception after edge N+1; the pipeline accepts one new operand pair every cycle, with no handshake.
REQ-009 Stage 1 SHALL register the following: sign = A[31] XOR B[31]; exponent sum = expA + expB - 127 in a signed 10-bit value; the 48-bit product of the 24-bit significands with the hidden 1; and the special-case class.
REQ-010 Stage 2 SHALL normalize the product: if product bit 47 is set, shift right by 1 and add 1 to the exponent; otherwise use it as is.
REQ-011 Stage 2 SHALL round to nearest, ties to even, using guard, round and sticky bits from the discarded product bits.
REQ-012 If rounding carries out of the significand, stage 2 SHALL renormalize by adding 1 to the exponent with fraction 0.
REQ-013 Subnormal inputs (exp=0) SHALL be treated as signed zero (flush-to-zero).
REQ-014 If the final biased exponent is <= 0, the result SHALL be signed zero, with exception=0.
REQ-015 If the final biased exponent is >= 255, the result SHALL be signed Inf (sign,0xFF,0), with exception=1.
REQ-016 If either input is NaN, or the inputs are zero*Inf, the result SHALL be the canonical NaN 0x7FC00000, with exception=1.
REQ-017 Inf*finite-nonzero and Inf*Inf SHALL give signed Inf, with exception=1.
REQ-018 Zero*finite SHALL give signed zero (sign = XOR of input signs), with exception=0.
REQ-019 In all other cases exception SHALL be 0.
REQ-020 SHALL be purely synchronous apart from reset; it SHALL have no combinational path from A/B to the outputs.

Reset
REQ-021 While reset_n=0, all pipeline registers, result and exception SHALL be 0 immediately, independent of clk.
REQ-022 After reset_n rises, the first valid result SHALL appear 2 edges after the operands are sampled; until then result stays 0x00000000.
REQ-023 Asserting reset_n mid-operation SHALL discard in-flight operands; no stale value appears after release.

Verification
REQ-024 Drive reset_n=0 with arbitrary A/B and toggle clk -> result=0x00000000, exception=0 throughout; release -> still 0 until 2 edges later.
REQ-025 Drive A=0x3F000000 (0.5), B=0xC00B4B4B -> after 2 edges result=0xBF8B4B4B, exception=0.
REQ-026 Drive back-to-back 0x3FC00000*0x40000000 then 0x3F800001*0x3F800001 on consecutive cycles -> result=0x40400000 then 0x3F800002 on consecutive cycles (rounding check), exception=0.
REQ-027 Drive 0x7F000000*0x40000000 -> 0x7F800000, exception=1; drive 0xFF000000*0x40000000 -> 0xFF800000, exception=1.
REQ-028 Drive 0x00000000*0x7F800000 -> 0x7FC00000, exception=1; drive 0x7FC00001*0x3F800000 -> 0x7FC00000, exception=1.
REQ-029 Drive 0x00800000*0x00800000 (underflow) -> 0x00000000, exception=0; drive 0x80000000*0x3F800000 -> 0x80000000, exception=0.
